// File: rtl/spi_byte_master_if.sv
// Byte-stream handshake between an upstream sequencer and spi_byte_master.
// The master modport is the byte producer; the slave modport is the SPI initiator.
interface spi_byte_master_if;
    logic [7:0] tx_data;
    logic       tx_last;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;

    modport master (
        output tx_data, tx_last, tx_valid,
        input  tx_ready, rx_data, rx_valid, busy
    );

    modport slave (
        input  tx_data, tx_last, tx_valid,
        output tx_ready, rx_data, rx_valid, busy
    );
endinterface

// File: rtl/spi_byte_master.sv
// SPI mode-0, LSB-first initiator fed by a byte stream; ss stays low across
// bytes until one is flagged last. All outputs come straight from registers.
module spi_byte_master #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned SS_SETUP = 2,
    parameter int unsigned SS_HOLD  = 2,
    parameter int unsigned SS_GAP   = 4
) (
    input  logic              clk,
    input  logic              rst,
    spi_byte_master_if.slave  bus,
    output logic              spi_sclk,
    output logic              spi_ss,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP    = 3'd1;
    localparam logic [2:0] S_LOW      = 3'd2;
    localparam logic [2:0] S_HIGH     = 3'd3;
    localparam logic [2:0] S_BYTE_END = 3'd4;
    localparam logic [2:0] S_WAIT     = 3'd5;
    localparam logic [2:0] S_HOLD     = 3'd6;
    localparam logic [2:0] S_GAP      = 3'd7;

    // Terminal counts; every timed state counts 0 .. N-1, so each parameter must be >= 1.
    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_LAST = 16'(SS_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(SS_HOLD - 1);
    localparam logic [15:0] GAP_LAST   = 16'(SS_GAP - 1);

    logic [2:0]  state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [2:0]  bit_idx, idx_n;
    logic [7:0]  tx_shift, shift_n;
    logic [7:0]  rx_shift, rx_n;
    logic        last_q, last_n;
    logic        handshake;

    assign handshake = bus.tx_valid && bus.tx_ready;

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = bit_idx;
        shift_n = tx_shift;
        last_n  = last_q;
        rx_n    = rx_shift;
        case (state)
            S_IDLE, S_WAIT: begin
                if (handshake) begin
                    shift_n = bus.tx_data;
                    last_n  = bus.tx_last;
                    cnt_n   = '0;
                    idx_n   = '0;
                    // Continuation bytes skip SETUP: ss is already low.
                    state_n = (state == S_IDLE) ? S_SETUP : S_LOW;
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = S_LOW;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_LOW: begin
                if (cnt == DIV_LAST) begin
                    cnt_n          = '0;
                    rx_n[bit_idx]  = spi_miso;
                    state_n        = S_HIGH;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_HIGH: begin
                if (cnt == DIV_LAST) begin
                    cnt_n = '0;
                    if (bit_idx != 3'd7) begin
                        idx_n   = bit_idx + 3'd1;
                        state_n = S_LOW;
                    end else begin
                        state_n = S_BYTE_END;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_BYTE_END: begin
                cnt_n   = '0;
                state_n = last_q ? S_HOLD : S_WAIT;
            end
            S_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    cnt_n   = '0;
                    state_n = S_GAP;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_GAP;
            cnt          <= '0;
            bit_idx      <= '0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            last_q       <= 1'b0;
            spi_sclk     <= 1'b0;
            spi_ss       <= 1'b1;
            spi_mosi     <= 1'b0;
            bus.tx_ready <= 1'b0;
            bus.rx_valid <= 1'b0;
            bus.rx_data  <= '0;
            bus.busy     <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= idx_n;
            tx_shift     <= shift_n;
            rx_shift     <= rx_n;
            last_q       <= last_n;
            spi_sclk     <= (state_n == S_HIGH);
            spi_ss       <= (state_n == S_IDLE) || (state_n == S_GAP);
            if (state_n == S_LOW) begin
                spi_mosi <= shift_n[idx_n];
            end
            bus.tx_ready <= (state_n == S_IDLE) || (state_n == S_WAIT);
            bus.rx_valid <= (state_n == S_BYTE_END);
            if (state_n == S_BYTE_END) begin
                bus.rx_data <= rx_n;
            end
            bus.busy     <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_spi_byte_master.sv
// Randomised scoreboard bench for spi_byte_master: a byte-level SPI slave model
// supplies miso, and monitors decode mosi, frames and rx_data against queues.
module tb_spi_byte_master;

    localparam int CLK_DIV  = 2;
    localparam int SS_SETUP = 2;
    localparam int SS_HOLD  = 2;
    localparam int SS_GAP   = 4;

    typedef logic [7:0] bytes_t[$];
    typedef struct {
        int nbytes;
        int low_len;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_sclk, spi_ss, spi_mosi, spi_miso;

    spi_byte_master_if bus ();

    spi_byte_master #(
        .CLK_DIV (CLK_DIV),
        .SS_SETUP(SS_SETUP),
        .SS_HOLD (SS_HOLD),
        .SS_GAP  (SS_GAP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .spi_sclk(spi_sclk),
        .spi_ss  (spi_ss),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] mosi_exp_q[$];
    logic [7:0] slave_q[$];
    logic [7:0] rx_exp_q[$];
    frame_t     frame_q[$];

    bit   loopback = 1'b0;
    int   hs_cyc = 0;
    int   exp_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_low(input int n);
        return SS_SETUP + n * (16 * CLK_DIV + 1) + (n - 1) + SS_HOLD;
    endfunction

    // ---------------- monitors and slave model (all sampled on negedge) ----------------
    logic       prev_sclk = 1'b0, prev_ss = 1'b1, prev_mosi = 1'b0, prev_rx_valid = 1'b0;
    logic [7:0] mbyte = '0;
    logic [7:0] sl_cur;
    int         mbit = 0, rises_win = 0, bytes_win = 0, low_len = 0;
    int         high_run = 0, ready_low = 0, last_high_run = 0, last_ready_low = 0;
    int         frames_done = 0, last_rx_cyc = 0, ss_rise_cyc = 0;
    frame_t     mon_f;

    always @(negedge clk) begin
        if (rst) begin
            prev_sclk = 1'b0; prev_ss = 1'b1; prev_mosi = 1'b0; prev_rx_valid = 1'b0;
            mbit = 0; rises_win = 0; bytes_win = 0; low_len = 0;
            high_run = 0; ready_low = 0;
            spi_miso = 1'b0;
        end else begin
            if (bus.rx_valid) begin
                check("rx_valid_single_cycle", prev_rx_valid, 1'b0);
                last_rx_cyc = cyc;
                if (rx_exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL rx_unexpected: rx_valid with data 0x%0h, no byte outstanding", bus.rx_data);
                end else begin
                    check("rx_data", bus.rx_data, rx_exp_q.pop_front());
                end
            end
            if (spi_sclk && prev_sclk) check("mosi_stable_while_sclk_high", spi_mosi, prev_mosi);
            if (spi_sclk && !prev_sclk) begin
                mbyte[mbit[2:0]] = spi_mosi;
                rises_win++;
                mbit++;
                if (mbit == 8) begin
                    mbit = 0;
                    bytes_win++;
                    if (mosi_exp_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL mosi_unexpected: decoded 0x%0h, no byte outstanding", mbyte);
                    end else begin
                        check("mosi_byte", mbyte, mosi_exp_q.pop_front());
                    end
                    if (slave_q.size() != 0) slave_q.delete(0);
                end
            end
            if (!spi_ss) begin
                if (prev_ss) begin
                    last_high_run  = high_run;
                    last_ready_low = ready_low;
                    low_len = 0; bytes_win = 0; rises_win = 0;
                end
                low_len++;
                check("busy_while_selected", bus.busy, 1'b1);
            end else begin
                if (!prev_ss) begin
                    frames_done++;
                    ss_rise_cyc = cyc;
                    high_run = 0; ready_low = 0;
                    if (frame_q.size() == 0) begin
                        n_checks++; n_fail++;
                        $display("FAIL frame_unexpected: ss window of %0d bytes", bytes_win);
                    end else begin
                        mon_f = frame_q.pop_front();
                        check("frame_bytes", bytes_win, mon_f.nbytes);
                        check("frame_sclk_rises", rises_win, 8 * mon_f.nbytes);
                        if (mon_f.low_len >= 0) check("frame_ss_low_cycles", low_len, mon_f.low_len);
                    end
                end
                high_run++;
                if (!bus.tx_ready) ready_low++;
                check("sclk_idle_low", spi_sclk, 1'b0);
            end
            prev_sclk = spi_sclk; prev_ss = spi_ss; prev_mosi = spi_mosi; prev_rx_valid = bus.rx_valid;
            // Slave presents the bit the master will sample on the next sclk rise.
            sl_cur   = (slave_q.size() != 0) ? slave_q[0] : 8'h00;
            spi_miso = loopback ? spi_mosi : sl_cur[mbit[2:0]];
        end
    end

    // ---------------- stimulus (driven at posedge + 1) ----------------
    task automatic send_byte(input logic [7:0] d, input logic last, input logic [7:0] sl);
        int n = 0;
        mosi_exp_q.push_back(d);
        slave_q.push_back(loopback ? d : sl);
        rx_exp_q.push_back(loopback ? d : sl);
        bus.tx_data  = d;
        bus.tx_last  = last;
        bus.tx_valid = 1'b1;
        while (!bus.tx_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("tx_ready_within_budget", bus.tx_ready, 1'b1);
        if (bus.tx_ready) begin
            hs_cyc = cyc;
            @(posedge clk); #1;
        end
        bus.tx_valid = 1'b0;
    endtask

    task automatic send_txn(input bytes_t data, input int stall_max);
        frame_q.push_back('{nbytes: data.size(), low_len: exp_low(data.size())});
        exp_frames++;
        foreach (data[i]) begin
            send_byte(data[i], (i == data.size() - 1), 8'($urandom));
            if (stall_max > 0) repeat ($urandom_range(0, stall_max)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_done < target && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        check("frames_completed", frames_done, target);
    endtask

    bytes_t bq;
    int     k;

    initial begin
        bus.tx_data = '0; bus.tx_last = 1'b0; bus.tx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ss", spi_ss, 1'b1);
        check("reset_sclk", spi_sclk, 1'b0);
        check("reset_mosi", spi_mosi, 1'b0);
        check("reset_tx_ready", bus.tx_ready, 1'b0);
        check("reset_rx_valid", bus.rx_valid, 1'b0);
        check("reset_rx_data", bus.rx_data, 8'h00);
        check("reset_busy", bus.busy, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single byte 0xa5, last on first byte.
        bq = '{8'ha5};
        send_txn(bq, 0);
        wait_frames(exp_frames);
        check("handshake_to_rx_valid", last_rx_cyc - hs_cyc, 1 + SS_SETUP + 16 * CLK_DIV);
        check("handshake_to_ss_rise", ss_rise_cyc - hs_cyc, 1 + SS_SETUP + 16 * CLK_DIV + 1 + SS_HOLD);

        // Loopback stream in one ss window.
        loopback = 1'b1;
        bq = '{8'hf0, 8'h00, 8'hff};
        send_txn(bq, 0);
        wait_frames(exp_frames);
        loopback = 1'b0;

        // Upstream stall of 10 cycles in WAIT.
        frame_q.push_back('{nbytes: 2, low_len: -1});
        exp_frames++;
        send_byte(8'h5a, 1'b0, 8'($urandom));
        k = 0;
        while (!bus.rx_valid && k < 200) begin @(posedge clk); #1; k++; end
        check("stall_first_byte_done", bus.rx_valid, 1'b1);
        @(posedge clk); #1;
        repeat (10) begin
            check("stall_ss_low", spi_ss, 1'b0);
            check("stall_sclk_low", spi_sclk, 1'b0);
            check("stall_tx_ready", bus.tx_ready, 1'b1);
            @(posedge clk); #1;
        end
        send_byte(8'hc3, 1'b1, 8'($urandom));
        wait_frames(exp_frames);
        check("resume_handshake_to_rx_valid", last_rx_cyc - hs_cyc, 16 * CLK_DIV + 1);

        // Back-to-back transactions: ss gap and tx_ready low during it.
        bq = '{8'h10};
        send_txn(bq, 0);
        bq = '{8'h20};
        send_txn(bq, 0);
        @(posedge clk); #1;
        check("gap_ss_high_at_least", (last_high_run >= SS_GAP), 1'b1);
        check("gap_tx_ready_low_cycles", last_ready_low, SS_GAP);
        wait_frames(exp_frames);

        // Reset during bit 4 of 0x33.
        send_byte(8'h33, 1'b1, 8'($urandom));
        k = 0;
        while (!(mbit == 4 && !spi_sclk) && k < 200) begin @(posedge clk); #1; k++; end
        check("reached_bit4", mbit, 4);
        rst = 1'b1;
        mosi_exp_q.delete(); slave_q.delete(); rx_exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check("abort_ss_high", spi_ss, 1'b1);
        check("abort_sclk_low", spi_sclk, 1'b0);
        check("abort_no_rx_valid", bus.rx_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.tx_ready && k < 50);
        check("tx_ready_cycles_after_reset", k, SS_GAP + 1);
        @(posedge clk); #1;

        // Randomised transactions.
        repeat (12) begin
            bq.delete();
            repeat ($urandom_range(1, 4)) bq.push_back(8'($urandom));
            loopback = 1'($urandom_range(0, 1));
            send_txn(bq, 3);
            wait_frames(exp_frames);
        end
        loopback = 1'b0;

        // Full frame then a separate command byte.
        bq.delete();
        bq.push_back(8'hf0);
        for (int i = 0; i < 32; i++) begin
            bq.push_back(8'hff);
            bq.push_back(8'(i));
            bq.push_back(8'hff);
        end
        send_txn(bq, 0);
        bq = '{8'h10};
        send_txn(bq, 0);
        wait_frames(exp_frames);

        repeat (20) @(posedge clk);
        #1;
        check("rx_queue_drained", rx_exp_q.size(), 0);
        check("mosi_queue_drained", mosi_exp_q.size(), 0);
        check("frame_queue_drained", frame_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
